kmeans_cluster_engine: RTL and testbench
========================================

KMEANS_CLUSTER_ENGINE -- requirements
Module: kmeans_cluster_engine

Interface
REQ-001 Parameter DATA_W, default 16, unsigned sample width.
REQ-002 Parameter N_PTS, default 16, number of points (power of two, 4..256).
REQ-003 Parameter K, default 4, number of clusters (2..8, K <= N_PTS).
REQ-004 Parameter MAX_ITER, default 15, iteration limit (1..255).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins clustering of loaded points.
REQ-008 ld_we, ld_addr[clog2(N_PTS)], ld_data[DATA_W]  in  point-memory write port.
REQ-009 busy  out  1  high while clustering.
REQ-010 done  out  1  one-cycle pulse at completion.
REQ-011 converged  out  1  valid from done until next start; 1 = stopped on no-change.
REQ-012 iter_cnt  out  8  iterations executed in the last run.
REQ-013 c_addr[clog2(K)] in, c_data[DATA_W] out  combinational centroid read port.

Function
REQ-014 FSM states: IDLE, INIT, ASSIGN, UPDATE, CHECK, FINISH.
REQ-015 IDLE: start=1 -> INIT next cycle, busy=1 from that cycle; start ignored in other states.
REQ-016 ld_we honoured only in IDLE; writes while busy are dropped.
REQ-017 INIT: K cycles, centroid[k] <= point[k]; clear iter_cnt, sums, counts.
REQ-018 ASSIGN: one point per cycle, N_PTS cycles; nearest centroid by |x - c_k| over all K in parallel; ties -> lowest index.
REQ-019 ASSIGN accumulates per-cluster sum (DATA_W+clog2(N_PTS) bits, no overflow) and count (clog2(N_PTS)+1 bits).
REQ-020 UPDATE: per cluster, new centroid = floor(sum/count) via sequential divider; count=0 keeps old centroid; a per-cluster changed flag is set if the value differs.
REQ-021 CHECK (1 cycle): iter_cnt++; no cluster changed -> FINISH with converged=1; else iter_cnt==MAX_ITER -> FINISH with converged=0; else clear sums/counts -> ASSIGN.
REQ-022 FINISH (1 cycle): done=1, busy=0 on the following cycle, return to IDLE.
REQ-023 Centroids, converged, iter_cnt hold their values in IDLE until the next start.

Reset
REQ-024 reset=1 at any state, including mid-run -> next cycle: state IDLE, busy=0, done=0, converged=0, iter_cnt=0, centroids=0, divider aborted.
REQ-025 Point memory contents are not cleared by reset.

Configuration
REQ-026 Macro KMEANS_LABEL_OUT_EN defined: ports lb_addr[clog2(N_PTS)] in, lb_data[clog2(K)] out give the final cluster label of each point (labels from last ASSIGN, reset to 0).
REQ-027 Macro undefined: label ports and label storage absent; all other behaviour identical.

Structure
REQ-028 Package kmeans_pkg: FSM state enum, width helper functions (sum/count widths), default parameter constants.
REQ-029 One sub-module kmeans_divider: restoring unsigned divider, start/done handshake, one quotient bit per cycle, synchronous reset abort.

Verification
REQ-030 N_PTS=8,K=2: points {1,2,3,4,100,101,102,103}, start -> done, c0=2, c1=101, converged=1, iter_cnt=3.
REQ-031 Same data, MAX_ITER=1 -> done, converged=0, iter_cnt=1, c0=1, c1=59.
REQ-032 All points =5, K=2 -> c0=5, c1=5 (empty cluster retained), converged=1, iter_cnt=1; with KMEANS_LABEL_OUT_EN all labels=0.
REQ-033 reset pulsed during ASSIGN -> next cycle busy=0, done=0, centroids 0; following start reproduces REQ-030 results.
REQ-034 start and ld_we asserted while busy -> ignored; results equal REQ-030, point memory unchanged.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared types and width helpers for the k-means clustering engine.
package kmeans_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_N_PTS    = 16;
  localparam int DEF_K        = 4;
  localparam int DEF_MAX_ITER = 15;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ASSIGN,
    UPDATE,
    CHECK,
    FINISH
  } state_t;

  // Width of a per-cluster sum: worst case is every point at full scale.
  function automatic int sum_w(input int data_w, input int n_pts);
    return data_w + $clog2(n_pts);
  endfunction

  // Width of a per-cluster count: must hold the value n_pts itself.
  function automatic int cnt_w(input int n_pts);
    return $clog2(n_pts) + 1;
  endfunction

endpackage

// File: rtl/kmeans_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// A start pulse while idle loads the operands; done pulses for one cycle
// when the quotient is valid. Reset aborts any division in progress.
module kmeans_divider #(
  parameter int DW = 20,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CNTW = $clog2(DW + 1);

  logic [DW-1:0]   q;
  logic [VW-1:0]   r;
  logic [CNTW-1:0] cnt;
  logic [VW:0]     shifted;
  logic [VW:0]     trial;
  logic            fits;

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    shifted = {r, q[DW-1]};
    fits    = (shifted >= {1'b0, divisor});
    trial   = shifted - {1'b0, divisor};
  end

  // Shift the dividend through, building the quotient in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      q    <= '0;
      r    <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        q    <= dividend;
        r    <= '0;
        cnt  <= CNTW'(DW);
        busy <= 1'b1;
      end else if (busy) begin
        if (fits) begin
          r <= trial[VW-1:0];
          q <= {q[DW-2:0], 1'b1};
        end else begin
          r <= shifted[VW-1:0];
          q <= {q[DW-2:0], 1'b0};
        end
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;

endmodule

// File: rtl/kmeans_cluster_engine.sv
// One-dimensional k-means clustering engine.
// Points are loaded through a write port while idle; a start pulse seeds the
// centroids from the first K points and iterates assign/update until no
// centroid moves or MAX_ITER iterations have run.
// Optional macro KMEANS_LABEL_OUT_EN adds a per-point label read port.
module kmeans_cluster_engine
  import kmeans_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_PTS    = DEF_N_PTS,
  parameter int K        = DEF_K,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ld_we,
  input  logic [$clog2(N_PTS)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [7:0]               iter_cnt,
`ifdef KMEANS_LABEL_OUT_EN
  input  logic [$clog2(N_PTS)-1:0] lb_addr,
  output logic [$clog2(K)-1:0]     lb_data,
`endif
  input  logic [$clog2(K)-1:0]     c_addr,
  output logic [DATA_W-1:0]        c_data
);

  localparam int PW = $clog2(N_PTS);
  localparam int KW = $clog2(K);
  localparam int SW = sum_w(DATA_W, N_PTS);
  localparam int CW = cnt_w(N_PTS);

  state_t            state;
  logic [DATA_W-1:0] pts  [N_PTS];
  logic [DATA_W-1:0] cent [K];
  logic [SW-1:0]     sums [K];
  logic [CW-1:0]     cnts [K];
  logic [K-1:0]      changed;
  logic [PW-1:0]     pt_idx;
  logic [KW-1:0]     kidx;
  logic              upd_wait;

  logic [DATA_W-1:0] cur_pt;
  logic [DATA_W-1:0] best_d;
  logic [DATA_W-1:0] dk;
  logic [KW-1:0]     best_k;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [SW-1:0]     div_q;
  logic [SW-1:0]     div_dividend;
  logic [CW-1:0]     div_divisor;
  logic [DATA_W-1:0] div_res;
  logic              unused_q_hi;

`ifdef KMEANS_LABEL_OUT_EN
  logic [KW-1:0]     lbl [N_PTS];
`endif

  function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Point memory: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_we && state == IDLE) pts[ld_addr] <= ld_data;
  end

  // Nearest-centroid search over all clusters; strict compare keeps the lowest index on ties.
  always_comb begin
    cur_pt = pts[pt_idx];
    best_k = '0;
    best_d = absdiff(cur_pt, cent[0]);
    dk     = '0;
    for (int unsigned k = 1; k < K; k++) begin
      dk = absdiff(cur_pt, cent[k]);
      if (dk < best_d) begin
        best_d = dk;
        best_k = KW'(k);
      end
    end
  end

  assign div_dividend = sums[kidx];
  assign div_divisor  = cnts[kidx];
  assign div_res      = div_q[DATA_W-1:0];
  // Quotient never exceeds the largest sample, so the top bits are always zero.
  assign unused_q_hi  = ^div_q[SW-1:DATA_W];

  kmeans_divider #(
    .DW(SW),
    .VW(CW)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  // Control FSM with registered status outputs and all clustering state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      iter_cnt  <= '0;
      changed   <= '0;
      pt_idx    <= '0;
      kidx      <= '0;
      upd_wait  <= 1'b0;
      div_start <= 1'b0;
      for (int unsigned k = 0; k < K; k++) begin
        cent[k] <= '0;
        sums[k] <= '0;
        cnts[k] <= '0;
      end
`ifdef KMEANS_LABEL_OUT_EN
      for (int unsigned p = 0; p < N_PTS; p++) lbl[p] <= '0;
`endif
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT;
            busy      <= 1'b1;
            converged <= 1'b0;
            kidx      <= '0;
          end
        end

        INIT: begin
          cent[kidx] <= pts[PW'(kidx)];
          iter_cnt   <= '0;
          changed    <= '0;
          for (int unsigned k = 0; k < K; k++) begin
            sums[k] <= '0;
            cnts[k] <= '0;
          end
          if (kidx == KW'(K - 1)) begin
            state  <= ASSIGN;
            pt_idx <= '0;
          end else begin
            kidx <= kidx + KW'(1);
          end
        end

        ASSIGN: begin
          sums[best_k] <= sums[best_k] + SW'(cur_pt);
          cnts[best_k] <= cnts[best_k] + CW'(1);
`ifdef KMEANS_LABEL_OUT_EN
          lbl[pt_idx]  <= best_k;
`endif
          if (pt_idx == PW'(N_PTS - 1)) begin
            state    <= UPDATE;
            kidx     <= '0;
            upd_wait <= 1'b0;
            changed  <= '0;
          end else begin
            pt_idx <= pt_idx + PW'(1);
          end
        end

        // Clusters are visited in order; empty clusters skip the divider and keep their centroid.
        UPDATE: begin
          if (!upd_wait) begin
            if (cnts[kidx] == '0) begin
              if (kidx == KW'(K - 1)) state <= CHECK;
              else                    kidx  <= kidx + KW'(1);
            end else if (!div_busy) begin
              div_start <= 1'b1;
              upd_wait  <= 1'b1;
            end
          end else if (div_done) begin
            upd_wait <= 1'b0;
            if (div_res != cent[kidx]) changed[kidx] <= 1'b1;
            cent[kidx] <= div_res;
            if (kidx == KW'(K - 1)) state <= CHECK;
            else                    kidx  <= kidx + KW'(1);
          end
        end

        CHECK: begin
          iter_cnt <= iter_cnt + 8'd1;
          if (changed == '0) begin
            state     <= FINISH;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (iter_cnt + 8'd1 == 8'(MAX_ITER)) begin
            state     <= FINISH;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            for (int unsigned k = 0; k < K; k++) begin
              sums[k] <= '0;
              cnts[k] <= '0;
            end
            pt_idx <= '0;
            state  <= ASSIGN;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign c_data = cent[c_addr];

`ifdef KMEANS_LABEL_OUT_EN
  assign lb_data = lbl[lb_addr];
`endif

endmodule

// File: tb/tb_kmeans_cluster_engine.sv
// Directed self-checking bench for kmeans_cluster_engine (N_PTS=8, K=2).
// Two instances share the load port: dut runs with MAX_ITER=15, dut1 with MAX_ITER=1.
module tb_kmeans_cluster_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start1;
  logic        ld_we;
  logic        ld_we1;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        busy, busy1;
  logic        done, done1;
  logic        converged, converged1;
  logic [7:0]  iter_cnt, iter_cnt1;
  logic [0:0]  c_addr;
  logic [15:0] c_data, c_data1;
`ifdef KMEANS_LABEL_OUT_EN
  logic [2:0]  lb_addr;
  logic [0:0]  lb_data, lb_data1;
`endif

  int n_checks;
  int n_fail;
  logic [15:0] vec [8];

  kmeans_cluster_engine #(
    .DATA_W(16), .N_PTS(8), .K(2), .MAX_ITER(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy), .done(done),
    .converged(converged), .iter_cnt(iter_cnt),
`ifdef KMEANS_LABEL_OUT_EN
    .lb_addr(lb_addr), .lb_data(lb_data),
`endif
    .c_addr(c_addr), .c_data(c_data)
  );

  kmeans_cluster_engine #(
    .DATA_W(16), .N_PTS(8), .K(2), .MAX_ITER(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ld_we(ld_we1),
    .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy1), .done(done1),
    .converged(converged1), .iter_cnt(iter_cnt1),
`ifdef KMEANS_LABEL_OUT_EN
    .lb_addr(lb_addr), .lb_data(lb_data1),
`endif
    .c_addr(c_addr), .c_data(c_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 8; i++) begin
      ld_we   = 1'b1;
      ld_we1  = 1'b1;
      ld_addr = 3'(i);
      ld_data = vec[i];
      tick();
    end
    ld_we  = 1'b0;
    ld_we1 = 1'b0;
  endtask

  // Pulse start on the selected instances and wait (bounded) for their done pulses.
  // With meddle set, start and a write to point 0 are driven while dut is busy.
  task automatic run(input bit s0, input bit s1, input bit meddle);
    bit seen0, seen1, post0;
    start  = s0;
    start1 = s1;
    tick();
    start  = 1'b0;
    start1 = 1'b0;
    if (s0) check("busy_after_start", busy, 1);
    seen0 = !s0;
    seen1 = !s1;
    post0 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (meddle && c >= 3 && c < 6) begin
        start   = 1'b1;
        ld_we   = 1'b1;
        ld_addr = 3'd0;
        ld_data = 16'd999;
      end else begin
        start = 1'b0;
        ld_we = 1'b0;
      end
      tick();
      if (post0) begin
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        post0 = 1'b0;
      end
      if (!seen0 && done) begin
        seen0 = 1'b1;
        post0 = 1'b1;
        check("busy_during_done", busy, 1);
      end
      if (!seen1 && done1) seen1 = 1'b1;
      if (seen0 && seen1 && !post0) break;
    end
    start = 1'b0;
    ld_we = 1'b0;
    check("done_seen", 32'({seen0, seen1}), 32'd3);
  endtask

  task automatic check_res(input string tag, input bit which, input int e0, input int e1,
                           input int ec, input int ei);
    c_addr = 1'b0;
    #1;
    check({tag, "_c0"}, which ? c_data1 : c_data, e0);
    c_addr = 1'b1;
    #1;
    check({tag, "_c1"}, which ? c_data1 : c_data, e1);
    check({tag, "_conv"}, which ? converged1 : converged, ec);
    check({tag, "_iter"}, which ? iter_cnt1 : iter_cnt, ei);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    start1   = 1'b0;
    ld_we    = 1'b0;
    ld_we1   = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    c_addr   = '0;
`ifdef KMEANS_LABEL_OUT_EN
    lb_addr  = '0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_res("rst", 1'b0, 0, 0, 0, 0);

    // Two well-separated groups.
    vec[0] = 16'd1;   vec[1] = 16'd2;   vec[2] = 16'd3;   vec[3] = 16'd4;
    vec[4] = 16'd100; vec[5] = 16'd101; vec[6] = 16'd102; vec[7] = 16'd103;
    load_all();
    run(1'b1, 1'b1, 1'b0);
    check_res("base", 1'b0, 2, 101, 1, 3);
    check_res("maxit1", 1'b1, 1, 59, 0, 1);
`ifdef KMEANS_LABEL_OUT_EN
    for (int i = 0; i < 8; i++) begin
      lb_addr = 3'(i);
      #1;
      check("label", lb_data, (i < 4) ? 0 : 1);
      check("label1", lb_data1, (i == 0) ? 0 : 1);
    end
`endif

    // Results hold while idle.
    repeat (5) tick();
    check_res("hold", 1'b0, 2, 101, 1, 3);

    // start and writes while busy must be dropped.
    run(1'b1, 1'b0, 1'b1);
    check_res("meddle", 1'b0, 2, 101, 1, 3);
    run(1'b1, 1'b0, 1'b0);
    check_res("mem_kept", 1'b0, 2, 101, 1, 3);

    // Reset in the middle of ASSIGN.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_res("midrst", 1'b0, 0, 0, 0, 0);
    run(1'b1, 1'b1, 1'b0);
    check_res("after_rst", 1'b0, 2, 101, 1, 3);
    check_res("after_rst1", 1'b1, 1, 59, 0, 1);

    // Identical points: second cluster stays empty and keeps its seed.
    for (int i = 0; i < 8; i++) vec[i] = 16'd5;
    load_all();
    run(1'b1, 1'b1, 1'b0);
    check_res("same", 1'b0, 5, 5, 1, 1);
    check_res("same1", 1'b1, 5, 5, 1, 1);
`ifdef KMEANS_LABEL_OUT_EN
    for (int i = 0; i < 8; i++) begin
      lb_addr = 3'(i);
      #1;
      check("same_label", lb_data, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
